// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage.
// Round-robin on contention, with a watchdog for accesses that never complete.
module mem_port_arbiter #(
   parameter int BITSIZE = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               resetn_i,
   input  logic [BITSIZE-1:0] IF_addr_i,
   input  logic               IF_read_i,
   output logic [BITSIZE-1:0] IF_data_o,
   output logic               IF_valid_o,
   output logic               IF_err_o,
   input  logic [BITSIZE-1:0] MEM_addr_i,
   input  logic [BITSIZE-1:0] MEM_data_i,
   input  logic               MEM_read_i,
   input  logic               MEM_write_i,
   input  logic [1:0]         MEM_write_size_i,
   output logic [BITSIZE-1:0] MEM_data_o,
   output logic               MEM_valid_o,
   output logic               MEM_err_o,
   output logic [BITSIZE-1:0] mem_addr_o,
   output logic [BITSIZE-1:0] mem_data_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic [1:0]         mem_write_size_o,
   input  logic [BITSIZE-1:0] mem_data_i,
   input  logic               mem_valid_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t             state_q, state_d;
   logic               last_mem_q, last_mem_d;
   logic               owner_mem_q, owner_mem_d;
   logic [BITSIZE-1:0] addr_q, addr_d;
   logic [BITSIZE-1:0] wdata_q, wdata_d;
   logic [1:0]         size_q, size_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BITSIZE-1:0] if_data_q, if_data_d;
   logic [BITSIZE-1:0] mem_rdata_q, mem_rdata_d;
   logic               if_valid_q, if_valid_d;
   logic               if_err_q, if_err_d;
   logic               mem_valid_q, mem_valid_d;
   logic               mem_err_q, mem_err_d;

   logic               if_req;
   logic               mem_req;
   logic               pick_mem;
   logic [CNT_W:0]     cnt_inc;
   logic               to_hit;

   assign if_req   = IF_read_i;
   assign mem_req  = MEM_read_i | MEM_write_i;
   // On a tie, serve whoever did not win last time.
   assign pick_mem = mem_req & (~if_req | ~last_mem_q);
   assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign to_hit   = (TIMEOUT != 0) &&
                     (cnt_inc == (CNT_W+1)'(TIMEOUT));

   always_comb begin
      state_d     = state_q;
      last_mem_d  = last_mem_q;
      owner_mem_d = owner_mem_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_valid_d  = 1'b0;
      if_err_d    = 1'b0;
      mem_valid_d = 1'b0;
      mem_err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (if_req | mem_req) begin
               owner_mem_d = pick_mem;
               last_mem_d  = pick_mem;
               cnt_d       = '0;
               state_d     = ACCESS;
               if (pick_mem) begin
                  addr_d  = MEM_addr_i;
                  wdata_d = MEM_data_i;
                  size_d  = MEM_write_size_i;
                  wr_d    = MEM_write_i;
                  rd_d    = ~MEM_write_i;
               end else begin
                  addr_d  = IF_addr_i;
                  wdata_d = '0;
                  size_d  = 2'b10;
                  wr_d    = 1'b0;
                  rd_d    = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (mem_valid_i || to_hit) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = RESP;
               if (owner_mem_q) begin
                  mem_valid_d = 1'b1;
                  mem_err_d   = ~mem_valid_i;
               end else begin
                  if_valid_d = 1'b1;
                  if_err_d   = ~mem_valid_i;
               end
            end
            if (mem_valid_i) begin
               if (rd_q && owner_mem_q) mem_rdata_d = mem_data_i;
               if (rd_q && !owner_mem_q) if_data_d = mem_data_i;
            end else begin
               cnt_d = cnt_inc[CNT_W-1:0];
               if (to_hit && owner_mem_q) mem_rdata_d = '0;
               if (to_hit && !owner_mem_q) if_data_d = '0;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q     <= IDLE;
         last_mem_q  <= 1'b0;
         owner_mem_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         if_valid_q  <= 1'b0;
         if_err_q    <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_mem_q  <= last_mem_d;
         owner_mem_q <= owner_mem_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         if_valid_q  <= if_valid_d;
         if_err_q    <= if_err_d;
         mem_valid_q <= mem_valid_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign IF_data_o        = if_data_q;
   assign IF_valid_o       = if_valid_q;
   assign IF_err_o         = if_err_q;
   assign MEM_data_o       = mem_rdata_q;
   assign MEM_valid_o      = mem_valid_q;
   assign MEM_err_o        = mem_err_q;
   assign mem_addr_o       = addr_q;
   assign mem_data_o       = wdata_q;
   assign mem_read_o       = rd_q;
   assign mem_write_o      = wr_q;
   assign mem_write_size_o = size_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, tie alternation, async reset.
// Expected completions are queued at drive time and popped on valid pulses.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn_i;
   logic [31:0] IF_addr_i;
   logic        IF_read_i;
   logic [31:0] IF_data_o;
   logic        IF_valid_o;
   logic        IF_err_o;
   logic [31:0] MEM_addr_i;
   logic [31:0] MEM_data_i;
   logic        MEM_read_i;
   logic        MEM_write_i;
   logic [1:0]  MEM_write_size_i;
   logic [31:0] MEM_data_o;
   logic        MEM_valid_o;
   logic        MEM_err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [1:0]  mem_write_size_o;
   logic [31:0] mem_data_i;
   logic        mem_valid_i;

   always #5 clk = ~clk;

   mem_port_arbiter #(.BITSIZE(32), .TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .resetn_i(resetn_i),
      .IF_addr_i(IF_addr_i), .IF_read_i(IF_read_i),
      .IF_data_o(IF_data_o), .IF_valid_o(IF_valid_o), .IF_err_o(IF_err_o),
      .MEM_addr_i(MEM_addr_i), .MEM_data_i(MEM_data_i),
      .MEM_read_i(MEM_read_i), .MEM_write_i(MEM_write_i),
      .MEM_write_size_i(MEM_write_size_i),
      .MEM_data_o(MEM_data_o), .MEM_valid_o(MEM_valid_o),
      .MEM_err_o(MEM_err_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_write_size_o(mem_write_size_o),
      .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i)
   );

   typedef struct {
      bit          mem;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      int          lat;
      logic [31:0] rdata;
      bit          drop;
      bit          exp_err;
      logic [31:0] exp_data;
      int          exp_strobes;
   } vec_t;

   typedef struct {
      bit          mem;
      bit          err;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[8];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no event expected one within bound", name);
   endtask

   task automatic quiet_inputs();
      IF_read_i   = 1'b0;
      MEM_read_i  = 1'b0;
      MEM_write_i = 1'b0;
      mem_valid_i = 1'b0;
   endtask

   function automatic vec_t mk(bit mem, bit rd, bit wr, logic [31:0] addr,
                               logic [31:0] wdata, logic [1:0] size, int lat,
                               logic [31:0] rdata, bit drop, bit exp_err,
                               logic [31:0] exp_data, int exp_strobes);
      vec_t v;
      v.mem = mem; v.rd = rd; v.wr = wr; v.addr = addr;
      v.wdata = wdata; v.size = size; v.lat = lat; v.rdata = rdata;
      v.drop = drop; v.exp_err = exp_err; v.exp_data = exp_data;
      v.exp_strobes = exp_strobes;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      int   k;
      bit   done;
      bit   w;
      exp_t e;
      w = v.mem & v.wr;
      @(negedge clk);
      if (v.mem) begin
         MEM_addr_i = v.addr; MEM_data_i = v.wdata;
         MEM_write_size_i = v.size;
         MEM_read_i = v.rd; MEM_write_i = v.wr;
      end else begin
         IF_addr_i = v.addr; IF_read_i = 1'b1;
      end
      e.mem = v.mem; e.err = v.exp_err; e.data = v.exp_data;
      sb.push_back(e);
      k = 0;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (IF_valid_o || MEM_valid_o) begin
            if (sb.size() == 0) begin
               flag_fail("sb_empty");
            end else begin
               e = sb.pop_front();
               chk("owner", {31'b0, MEM_valid_o}, {31'b0, e.mem});
               chk("one_valid", {31'b0, IF_valid_o & MEM_valid_o}, 32'd0);
               chk("err", {31'b0, e.mem ? MEM_err_o : IF_err_o},
                   {31'b0, e.err});
               chk("data", e.mem ? MEM_data_o : IF_data_o, e.data);
               chk("resp_strobe", {31'b0, mem_read_o | mem_write_o}, 32'd0);
               chk("strobe_cycles", k, v.exp_strobes);
            end
            quiet_inputs();
            done = 1;
         end else if (mem_read_o || mem_write_o) begin
            chk("strobe_addr", mem_addr_o, v.addr);
            chk("strobe_op", {30'b0, mem_read_o, mem_write_o},
                {30'b0, ~w, w});
            chk("strobe_size", {30'b0, mem_write_size_o},
                {30'b0, v.mem ? v.size : 2'b10});
            if (w) chk("strobe_wdata", mem_data_o, v.wdata);
            if (v.drop) begin
               IF_read_i = 1'b0; MEM_read_i = 1'b0; MEM_write_i = 1'b0;
            end
            mem_valid_i = (k == v.lat);
            mem_data_i  = v.rdata;
            k++;
         end else begin
            mem_valid_i = 1'b0;
         end
      end
      if (!done) begin
         flag_fail("txn_timeout");
         quiet_inputs();
      end
   endtask

   initial begin
      int   nval;
      int   last_cyc;
      exp_t e;
      resetn_i = 1'b0;
      IF_addr_i = '0; MEM_addr_i = '0; MEM_data_i = '0;
      MEM_write_size_i = '0; mem_data_i = '0;
      quiet_inputs();

      tbl[0] = mk(0,1,0,32'h100,32'h0,2'b10,2,32'hDEADBEEF,0,0,32'hDEADBEEF,3);
      tbl[1] = mk(1,1,0,32'h200,32'h0,2'b10,0,32'h12345678,0,0,32'h12345678,1);
      tbl[2] = mk(1,0,1,32'h40,32'hAB,2'b00,1,32'hFFFFFFFF,0,0,32'h12345678,2);
      tbl[3] = mk(1,1,0,32'h300,32'h0,2'b10,9,32'h77777777,0,1,32'h0,4);
      tbl[4] = mk(0,1,0,32'h104,32'h0,2'b10,3,32'hCAFEF00D,0,0,32'hCAFEF00D,4);
      tbl[5] = mk(1,1,1,32'h44,32'h5555AAAA,2'b01,0,32'h99999999,0,0,32'h0,1);
      tbl[6] = mk(0,1,0,32'h108,32'h0,2'b10,9,32'h66666666,0,1,32'h0,4);
      tbl[7] = mk(0,1,0,32'h10C,32'h0,2'b10,1,32'h0BADF00D,1,0,32'h0BADF00D,2);

      @(negedge clk);
      chk("rst_strobes", {30'b0, mem_read_o, mem_write_o}, 32'd0);
      chk("rst_valids", {30'b0, IF_valid_o, MEM_valid_o}, 32'd0);
      chk("rst_errs", {30'b0, IF_err_o, MEM_err_o}, 32'd0);
      chk("rst_if_data", IF_data_o, 32'd0);
      chk("rst_mem_data", MEM_data_o, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      resetn_i = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(tbl[i]);

      // Tie from reset: MEM first, then strict alternation.
      @(negedge clk);
      resetn_i = 1'b0;
      @(negedge clk);
      resetn_i = 1'b1;
      MEM_addr_i = 32'h200; MEM_read_i = 1'b1; MEM_write_i = 1'b0;
      IF_addr_i  = 32'h100; IF_read_i  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e.mem  = (i % 2 == 0);
         e.err  = 1'b0;
         e.data = e.mem ? 32'h1200 : 32'h1100;
         sb.push_back(e);
      end
      nval = 0;
      last_cyc = 0;
      for (int c = 0; c < 40 && nval < 4; c++) begin
         @(negedge clk);
         if (IF_valid_o || MEM_valid_o) begin
            e = sb.pop_front();
            chk("alt_owner", {31'b0, MEM_valid_o}, {31'b0, e.mem});
            chk("alt_one_valid", {31'b0, IF_valid_o & MEM_valid_o}, 32'd0);
            chk("alt_data", e.mem ? MEM_data_o : IF_data_o, e.data);
            if (nval > 0) chk("alt_period", c - last_cyc, 32'd3);
            last_cyc = c;
            nval++;
            mem_valid_i = 1'b0;
            if (nval == 4) quiet_inputs();
         end else if (mem_read_o) begin
            chk("alt_addr", mem_addr_o, sb[0].mem ? 32'h200 : 32'h100);
            mem_valid_i = 1'b1;
            mem_data_i  = mem_addr_o + 32'h1000;
         end else begin
            mem_valid_i = 1'b0;
         end
      end
      if (nval != 4) begin
         flag_fail("alt_timeout");
         quiet_inputs();
         sb.delete();
      end

      // Asynchronous reset while an access is outstanding.
      @(negedge clk);
      IF_addr_i = 32'h500; IF_read_i = 1'b1;
      @(negedge clk);
      chk("mid_strobe", {31'b0, mem_read_o}, 32'd1);
      #2 resetn_i = 1'b0;
      #1;
      chk("mid_rst_strobe", {30'b0, mem_read_o, mem_write_o}, 32'd0);
      chk("mid_rst_valid", {30'b0, IF_valid_o, MEM_valid_o}, 32'd0);
      IF_read_i = 1'b0;
      @(negedge clk);
      resetn_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_quiet",
             {28'b0, IF_valid_o, MEM_valid_o, mem_read_o, mem_write_o},
             32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory port between the instruction-fetch requester (IF, read-only) and the data requester (MEM stage, load/store). Each requester holds read or write asserted until it receives its valid pulse, then releases. The arbiter registers the winner's request and drives the memory port. When both requesters contend, it alternates grants round-robin. A watchdog aborts accesses that the memory never acknowledges.

Parameters:
BITSIZE, 32, width of address and data buses
TIMEOUT, 255, cycles in ACCESS before abort; 0 disables the watchdog
CNT_W, 8, watchdog counter width; must satisfy TIMEOUT < 2^CNT_W

Ports:
clk  in  1  clock, rising edge
resetn_i  in  1  asynchronous active-low reset
IF_addr_i  in  BITSIZE  fetch address
IF_read_i  in  1  fetch request, held until IF_valid_o
IF_data_o  out  BITSIZE  fetched word
IF_valid_o  out  1  one-cycle completion pulse to IF
IF_err_o  out  1  completion was a timeout; qualified by IF_valid_o
MEM_addr_i  in  BITSIZE  data address
MEM_data_i  in  BITSIZE  store data
MEM_read_i  in  1  load request, held until MEM_valid_o
MEM_write_i  in  1  store request, held until MEM_valid_o
MEM_write_size_i  in  2  00 byte, 01 half, 10 word
MEM_data_o  out  BITSIZE  load data
MEM_valid_o  out  1  one-cycle completion pulse to MEM
MEM_err_o  out  1  completion was a timeout; qualified by MEM_valid_o
mem_addr_o  out  BITSIZE  memory address
mem_data_o  out  BITSIZE  memory write data
mem_read_o  out  1  memory read strobe, held until mem_valid_i
mem_write_o  out  1  memory write strobe, held until mem_valid_i
mem_write_size_o  out  2  memory access size
mem_data_i  in  BITSIZE  memory read data
mem_valid_i  in  1  memory completion

Behaviour:
- Clock is clk. Reset is resetn_i: asynchronous, active-low.
- Reset values:
  - State IDLE; last_grant = IF, so the first tie goes to MEM.
  - All *_valid_o, *_err_o, mem_read_o and mem_write_o are 0.
  - All data, address and size registers are 0.
- Reset asserted mid-access forces IDLE immediately; the in-flight access is dropped and no valid pulse is issued.
- State IDLE:
  - Sample requests. A MEM request is MEM_read_i | MEM_write_i.
  - Only one requester asserting: grant it.
  - Both asserting: grant the requester that is not last_grant.
  - On a grant: latch addr, wdata, size, op (read/write) and owner into registers; update last_grant; clear the watchdog; go to ACCESS.
  - The IF op is always read with size 10.
  - MEM_read_i and MEM_write_i both asserted: treated as a write.
  - No request: stay in IDLE.
- State ACCESS:
  - mem_addr_o, mem_data_o and mem_write_size_o come from the registers.
  - mem_read_o or mem_write_o equals the latched op and is held steady.
  - Requester inputs are ignored.
  - mem_valid_i = 1: latch mem_data_i into the owner's data_o register (loads only; stores leave it unchanged); err = 0; go to RESP.
  - Otherwise the watchdog increments. When the count reaches TIMEOUT (TIMEOUT != 0): data_o = 0, err = 1, go to RESP.
  - mem_valid_i arriving in the same cycle as the timeout: the valid wins and err = 0.
- State RESP:
  - Exactly one cycle. The owner's *_valid_o = 1 with its *_err_o; the other requester's outputs stay 0.
  - mem strobes are 0.
  - Next state is IDLE unconditionally.
- Throughput: request seen at cycle N, strobe from N+1, mem_valid_i at cycle M, requester valid at M+1, IDLE again at M+2.
  - A back-to-back request from the same requester is granted at M+2 at the earliest.
  - With memory answering in the strobe cycle, one access completes every 3 cycles.
- A requester must deassert its request in the cycle after its valid pulse. IDLE never re-grants a request answered in the preceding RESP.
- A requester dropping its request during ACCESS does not cancel the access; it still receives its valid pulse.
- *_data_o registers hold their value between accesses.

Test Plan:
- Reset: resetn_i low mid-cycle → all strobes and valids 0 asynchronously, before the next edge.
- Lone fetch: IF_read_i=1, IF_addr_i=0x100, mem answers 0xDEADBEEF 2 cycles later → mem_read_o asserted with mem_addr_o=0x100, size 10 → IF_valid_o pulses 1 cycle with IF_data_o=0xDEADBEEF, IF_err_o=0.
- Tie then alternation: both requesters held continuously from reset (MEM load 0x200, IF 0x100) → grants alternate MEM, IF, MEM, IF; each completion produces one valid pulse on the owner only.
- Store: MEM_write_i=1, addr 0x40, data 0x000000AB, size 00 → mem_write_o=1, mem_data_o=0xAB, mem_write_size_o=00 until mem_valid_i → MEM_valid_o pulse; MEM_data_o unchanged.
- Watchdog: TIMEOUT=4, memory never responds → strobe is high for exactly 4 cycles, then MEM_valid_o=1, MEM_err_o=1, MEM_data_o=0 → state returns to IDLE.
- Edge race: mem_valid_i arrives in the same cycle the count reaches TIMEOUT → err=0 and read data delivered.
